// File: rtl/uart_pkg.sv
// Shared state types and helpers for the parametrised UART.
package uart_pkg;

   localparam int unsigned MAX_DATA_BITS    = 9;
   localparam int unsigned DEF_CLKS_PER_BIT = 434;
   localparam int unsigned DEF_CNT_W        = $clog2(DEF_CLKS_PER_BIT);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
   } rx_state_t;

   function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

   // Narrower payloads are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, with mid-bit and end-of-bit ticks.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic nRst,
   input  logic clr,
   output logic half_tick,
   output logic full_tick
);

   localparam int unsigned      CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)                  count <= '0;
      else if (clr || full_tick)  count <= '0;
      else                        count <= count + CNT_W'(1);
   end

   assign half_tick = (count == HALF);
   assign full_tick = (count == LAST);

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: independent TX and RX FSMs, each with its own bit timer.
module uart_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 transmit,
   input  logic [DATA_BITS-1:0] data_tx,
   output logic                 busy_tx,
   output logic                 tx,
   input  logic                 rx,
   output logic                 busy_rx,
   output logic [DATA_BITS-1:0] data_rx,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic       PAR_EN    = (PARITY_EN != 0);
   localparam logic       PAR_ODD   = (PARITY_ODD != 0);

   // ---------------- TX ----------------
   tx_state_t            tx_state, tx_state_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   logic [3:0]           tx_bit, tx_bit_n;
   logic                 tx_par, tx_par_n, tx_line_n, busy_tx_n;
   logic                 tx_clr, tx_full, tx_half_unused;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk(clk), .nRst(nRst), .clr(tx_clr), .half_tick(tx_half_unused), .full_tick(tx_full)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_bit   <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
         busy_tx  <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_shift <= tx_shift_n;
         tx_bit   <= tx_bit_n;
         tx_par   <= tx_par_n;
         tx       <= tx_line_n;
         busy_tx  <= busy_tx_n;
      end
   end

   // tx is registered, so each branch loads the level of the bit that starts next cycle.
   always_comb begin
      tx_state_n = tx_state;
      tx_shift_n = tx_shift;
      tx_bit_n   = tx_bit;
      tx_par_n   = tx_par;
      tx_line_n  = tx;
      busy_tx_n  = busy_tx;
      tx_clr     = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_clr    = 1'b1;
            tx_line_n = 1'b1;
            busy_tx_n = 1'b0;
            if (transmit) begin
               tx_shift_n = data_tx;
               tx_par_n   = parity_calc(MAX_DATA_BITS'(data_tx), PAR_ODD);
               tx_bit_n   = '0;
               tx_state_n = TX_START;
               tx_line_n  = 1'b0;
               busy_tx_n  = 1'b1;
            end
         end
         TX_START: if (tx_full) begin
            tx_state_n = TX_DATA;
            tx_line_n  = tx_shift[0];
         end
         TX_DATA: if (tx_full) begin
            tx_shift_n = tx_shift >> 1;
            if (tx_bit == LAST_DATA) begin
               tx_bit_n = '0;
               if (PAR_EN) begin
                  tx_state_n = TX_PARITY;
                  tx_line_n  = tx_par;
               end else begin
                  tx_state_n = TX_STOP;
                  tx_line_n  = 1'b1;
               end
            end else begin
               tx_bit_n  = tx_bit + 4'd1;
               tx_line_n = tx_shift[1];
            end
         end
         TX_PARITY: if (tx_full) begin
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
         end
         TX_STOP: if (tx_full) begin
            if (tx_bit == LAST_STOP) begin
               tx_state_n = TX_IDLE;
               busy_tx_n  = 1'b0;
            end else begin
               tx_bit_n = tx_bit + 4'd1;
            end
         end
         default: begin
            tx_state_n = TX_IDLE;
            tx_line_n  = 1'b1;
            busy_tx_n  = 1'b0;
            tx_clr     = 1'b1;
         end
      endcase
   end

   // ---------------- RX ----------------
   logic [1:0]           rx_sync;
   logic                 rxs;
   rx_state_t            rx_state, rx_state_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n, data_rx_n;
   logic [3:0]           rx_bit, rx_bit_n;
   logic                 rx_par, rx_par_n, rx_ferr, rx_ferr_n, busy_rx_n;
   logic                 rx_valid_n, frame_err_n, parity_err_n;
   logic                 rx_clr, rx_half, rx_full;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk(clk), .nRst(nRst), .clr(rx_clr), .half_tick(rx_half), .full_tick(rx_full)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) rx_sync <= '1;
      else       rx_sync <= {rx_sync[0], rx};
   end
   assign rxs = rx_sync[1];

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rx_state      <= RX_IDLE;
         rx_shift      <= '0;
         rx_bit        <= '0;
         rx_par        <= 1'b0;
         rx_ferr       <= 1'b0;
         busy_rx       <= 1'b0;
         data_rx       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         rx_state      <= rx_state_n;
         rx_shift      <= rx_shift_n;
         rx_bit        <= rx_bit_n;
         rx_par        <= rx_par_n;
         rx_ferr       <= rx_ferr_n;
         busy_rx       <= busy_rx_n;
         data_rx       <= data_rx_n;
         rx_valid      <= rx_valid_n;
         rx_frame_err  <= frame_err_n;
         rx_parity_err <= parity_err_n;
      end
   end

   // The start bit is re-checked at half a period; clearing the timer there puts later samples mid-bit.
   always_comb begin
      rx_state_n   = rx_state;
      rx_shift_n   = rx_shift;
      rx_bit_n     = rx_bit;
      rx_par_n     = rx_par;
      rx_ferr_n    = rx_ferr;
      busy_rx_n    = busy_rx;
      data_rx_n    = data_rx;
      rx_valid_n   = 1'b0;
      frame_err_n  = 1'b0;
      parity_err_n = 1'b0;
      rx_clr       = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_clr    = 1'b1;
            busy_rx_n = 1'b0;
            if (!rxs) begin
               rx_state_n = RX_START;
               busy_rx_n  = 1'b1;
            end
         end
         RX_START: if (rx_half) begin
            if (rxs) begin
               rx_state_n = RX_IDLE;
               busy_rx_n  = 1'b0;
            end else begin
               rx_clr     = 1'b1;
               rx_bit_n   = '0;
               rx_ferr_n  = 1'b0;
               rx_state_n = RX_DATA;
            end
         end
         RX_DATA: if (rx_full) begin
            rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_DATA) begin
               rx_bit_n   = '0;
               rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
            end else begin
               rx_bit_n = rx_bit + 4'd1;
            end
         end
         RX_PARITY: if (rx_full) begin
            rx_par_n   = rxs;
            rx_state_n = RX_STOP;
         end
         RX_STOP: if (rx_full) begin
            if (rx_bit == LAST_STOP) begin
               data_rx_n    = rx_shift;
               rx_valid_n   = 1'b1;
               frame_err_n  = rx_ferr | ~rxs;
               parity_err_n = PAR_EN & (rx_par != parity_calc(MAX_DATA_BITS'(rx_shift), PAR_ODD));
               if (frame_err_n) begin
                  rx_state_n = RX_BREAK;
               end else begin
                  rx_state_n = RX_IDLE;
                  busy_rx_n  = 1'b0;
               end
            end else begin
               rx_ferr_n = rx_ferr | ~rxs;
               rx_bit_n  = rx_bit + 4'd1;
            end
         end
         RX_BREAK: if (rxs) begin
            rx_state_n = RX_IDLE;
            busy_rx_n  = 1'b0;
         end
         default: begin
            rx_state_n = RX_IDLE;
            busy_rx_n  = 1'b0;
            rx_clr     = 1'b1;
         end
      endcase
   end

endmodule
